// File: rtl/tone_gen.sv
// tone_gen: square-wave tone generator driven by one-hot note enables.
// A half-period down-counter toggles audio_out at each boundary. Note changes
// and releases are honoured only at a boundary, so no runt pulses occur.
// Optional feature macro: TONE_OCTAVE_SHIFT_EN adds oct_up, which halves the
// half-period (one octave up). The halving is latched at boundaries.
//
// state   | meaning
// IDLE    | silent, waiting for any note enable
// PLAY    | tone sounding, at least one note enable present
// RELEASE | all enables gone, finishing the current half-cycle
`timescale 1ns/1ps
module tone_gen #(
  parameter int CLK_HZ = 50000000,
  parameter int DIV_W  = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_note,
`ifdef TONE_OCTAVE_SHIFT_EN
  input  logic       oct_up,
`endif
  output logic       audio_out,
  output logic       note_active,
  output logic [2:0] note_idx
);

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

  localparam logic [DIV_W-1:0] HALF_0 = DIV_W'(CLK_HZ / (2 * 262));
  localparam logic [DIV_W-1:0] HALF_1 = DIV_W'(CLK_HZ / (2 * 294));
  localparam logic [DIV_W-1:0] HALF_2 = DIV_W'(CLK_HZ / (2 * 330));
  localparam logic [DIV_W-1:0] HALF_3 = DIV_W'(CLK_HZ / (2 * 349));
  localparam logic [DIV_W-1:0] HALF_4 = DIV_W'(CLK_HZ / (2 * 392));
  localparam logic [DIV_W-1:0] HALF_5 = DIV_W'(CLK_HZ / (2 * 440));
  localparam logic [DIV_W-1:0] HALF_6 = DIV_W'(CLK_HZ / (2 * 494));
  localparam logic [DIV_W-1:0] HALF_7 = DIV_W'(CLK_HZ / (2 * 523));

  state_t           state, state_nx;
  logic [7:0]       en_q;
  logic             none;
  logic [2:0]       sel;
  logic [DIV_W-1:0] half_sel, half_eff, reload;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic             audio_nx, active_nx;
  logic [2:0]       idx_nx;

`ifdef TONE_OCTAVE_SHIFT_EN
  logic oct_q;

  // Register the octave request alongside the note enables.
  always_ff @(posedge clk) begin
    if (!rst_n) oct_q <= 1'b0;
    else        oct_q <= oct_up;
  end

  assign half_eff = oct_q ? (half_sel >> 1) : half_sel;
`else
  assign half_eff = half_sel;
`endif

  assign none   = (en_q == 8'h00);
  assign reload = half_eff - DIV_W'(1);

  // Register the note enables every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) en_q <= 8'h00;
    else        en_q <= en_note;
  end

  // Lowest set enable wins when several are held.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (en_q[i]) sel = 3'(i);
    end
  end

  // Half-period lookup for the selected note.
  always_comb begin
    case (sel)
      3'd0:    half_sel = HALF_0;
      3'd1:    half_sel = HALF_1;
      3'd2:    half_sel = HALF_2;
      3'd3:    half_sel = HALF_3;
      3'd4:    half_sel = HALF_4;
      3'd5:    half_sel = HALF_5;
      3'd6:    half_sel = HALF_6;
      default: half_sel = HALF_7;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      audio_out   <= 1'b0;
      note_active <= 1'b0;
      note_idx    <= 3'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      audio_out   <= audio_nx;
      note_active <= active_nx;
      note_idx    <= idx_nx;
    end
  end

  // Next-state logic; PLAY and RELEASE share the boundary handling since a
  // held enable at a RELEASE boundary behaves exactly like a PLAY boundary.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    audio_nx  = audio_out;
    active_nx = note_active;
    idx_nx    = note_idx;
    case (state)
      IDLE: begin
        audio_nx  = 1'b0;
        active_nx = 1'b0;
        if (!none) begin
          state_nx  = PLAY;
          audio_nx  = 1'b1;
          active_nx = 1'b1;
          cnt_nx    = reload;
          idx_nx    = sel;
        end
      end
      PLAY, RELEASE: begin
        if (cnt == '0) begin
          if (none) begin
            state_nx  = IDLE;
            audio_nx  = 1'b0;
            active_nx = 1'b0;
          end else begin
            state_nx = PLAY;
            audio_nx = ~audio_out;
            cnt_nx   = reload;
            idx_nx   = sel;
          end
        end else begin
          cnt_nx   = cnt - DIV_W'(1);
          state_nx = none ? RELEASE : PLAY;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: randomized and directed checks of tone_gen against a
// behavioural model that tracks "clocks left in the current half".
`timescale 1ns/1ps
module tb_tone_gen;
  localparam int CLK_HZ = 8800;
  localparam int DIV_W  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] en_note;
  logic       oct_up;
  logic       audio_out;
  logic       note_active;
  logic [2:0] note_idx;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit         m_active, m_level, m_oct;
  int         m_note, m_left;
  logic [7:0] m_enq;

  tone_gen #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_note(en_note),
`ifdef TONE_OCTAVE_SHIFT_EN
    .oct_up(oct_up),
`endif
    .audio_out(audio_out),
    .note_active(note_active),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  function automatic int half_of(int n, bit oct);
    int f, h;
    case (n)
      0: f = 262; 1: f = 294; 2: f = 330; 3: f = 349;
      4: f = 392; 5: f = 440; 6: f = 494; default: f = 523;
    endcase
    h = CLK_HZ / (2 * f);
    return oct ? h / 2 : h;
  endfunction

  function automatic int low_of(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_active = 0; m_level = 0; m_note = 0; m_left = 0; m_enq = 8'h00; m_oct = 0;
    end else begin
      if (!m_active) begin
        if (m_enq != 8'h00) begin
          m_active = 1; m_level = 1; m_note = low_of(m_enq);
          m_left = half_of(m_note, m_oct);
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_enq == 8'h00) begin
            m_active = 0; m_level = 0;
          end else begin
            m_level = !m_level; m_note = low_of(m_enq);
            m_left = half_of(m_note, m_oct);
          end
        end
      end
      m_enq = en_note;
`ifdef TONE_OCTAVE_SHIFT_EN
      m_oct = oct_up;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_note = 8'h20; oct_up = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({audio_out, note_active, note_idx} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, want 00000", {audio_out, note_active, note_idx});
    end
    rst_n = 1'b1; en_note = 8'h00;
    tick();
    n_cmp++;
    if ({audio_out, note_active} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: got %b, want 00", {audio_out, note_active});
    end
  endtask

  task automatic test_note_a();
    en_note = 8'h20;
    tick();
    n_cmp++;
    if (audio_out !== 1'b0) begin
      n_bad++; $display("FAIL a_latency1: audio %b, want 0", audio_out);
    end
    tick();
    n_cmp++;
    if ({audio_out, note_active, note_idx} !== 5'b11_101) begin
      n_bad++; $display("FAIL a_start: got %b, want 11101", {audio_out, note_active, note_idx});
    end
    for (int k = 0; k < 45; k++) begin
      tick();
      n_cmp++;
      if (audio_out !== m_level || note_active !== m_active ||
          (m_active && note_idx !== m_note[2:0])) begin
        n_bad++;
        $display("FAIL a_hold cyc %0d: got a=%b act=%b idx=%0d, want a=%b act=%b idx=%0d",
                 k, audio_out, note_active, note_idx, m_level, m_active, m_note);
      end
    end
  endtask

  task automatic test_note_change();
    bit   found = 0;
    logic lvl;
    en_note = 8'h20;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (m_active && m_note == 5 && m_left == half_of(5, 0)) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL chg_sync: half start not reached, found=%0d want 1", found);
    end
    tick(); tick(); tick();
    lvl = audio_out;
    en_note = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++;
      if (k < 7 && (audio_out !== lvl || note_idx !== 3'd5)) begin
        n_bad++; $display("FAIL chg_hold k=%0d: a=%b idx=%0d, want a=%b idx=5", k, audio_out, note_idx, lvl);
      end else if (k == 7 && (audio_out !== ~lvl || note_idx !== 3'd0)) begin
        n_bad++; $display("FAIL chg_edge: a=%b idx=%0d, want a=%b idx=0", audio_out, note_idx, ~lvl);
      end
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      n_cmp++;
      if (audio_out !== m_level || note_active !== m_active ||
          (m_active && note_idx !== m_note[2:0])) begin
        n_bad++;
        $display("FAIL chg_run cyc %0d: got a=%b act=%b idx=%0d, want a=%b act=%b idx=%0d",
                 k, audio_out, note_active, note_idx, m_level, m_active, m_note);
      end
    end
  endtask

  task automatic test_multi_hot();
    en_note = 8'h00;
    for (int k = 0; k < 40 && m_active; k++) tick();
    n_cmp++;
    if (note_active !== 1'b0 || audio_out !== 1'b0) begin
      n_bad++; $display("FAIL mh_idle: act=%b a=%b, want 0 0", note_active, audio_out);
    end
    en_note = 8'h21;
    tick(); tick();
    n_cmp++;
    if ({audio_out, note_active, note_idx} !== 5'b11_000) begin
      n_bad++; $display("FAIL mh_start: got %b, want 11000", {audio_out, note_active, note_idx});
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++;
      if (audio_out !== (k < 16)) begin
        n_bad++; $display("FAIL mh_half k=%0d: a=%b, want %0d", k, audio_out, (k < 16));
      end
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      n_cmp++;
      if (audio_out !== m_level || note_active !== m_active ||
          (m_active && note_idx !== m_note[2:0])) begin
        n_bad++;
        $display("FAIL mh_run cyc %0d: got a=%b act=%b idx=%0d, want a=%b act=%b idx=%0d",
                 k, audio_out, note_active, note_idx, m_level, m_active, m_note);
      end
    end
  endtask

  task automatic test_release();
    bit found = 0;
    en_note = 8'h20;
    for (int k = 0; k < 120 && !found; k++) begin
      tick();
      if (m_active && m_note == 5 && m_level && m_left == half_of(5, 0)) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL rel_sync: high half start not reached, found=%0d want 1", found);
    end
    tick(); tick(); tick(); tick();
    en_note = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if (k < 6 && {audio_out, note_active} !== 2'b11) begin
        n_bad++; $display("FAIL rel_hold k=%0d: a/act=%b, want 11", k, {audio_out, note_active});
      end else if (k == 6 && {audio_out, note_active} !== 2'b00) begin
        n_bad++; $display("FAIL rel_end: a/act=%b, want 00", {audio_out, note_active});
      end
    end
  endtask

  task automatic test_reset_mid();
    en_note = 8'h20;
    for (int k = 0; k < 15; k++) tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({audio_out, note_active, note_idx} !== 5'b0) begin
      n_bad++; $display("FAIL rst_mid: got %b, want 00000", {audio_out, note_active, note_idx});
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({audio_out, note_active} !== 2'b00) begin
      n_bad++; $display("FAIL rst_wait: got %b, want 00", {audio_out, note_active});
    end
    tick();
    n_cmp++;
    if ({audio_out, note_active, note_idx} !== 5'b11_101) begin
      n_bad++; $display("FAIL rst_restart: got %b, want 11101", {audio_out, note_active, note_idx});
    end
  endtask

`ifdef TONE_OCTAVE_SHIFT_EN
  task automatic test_octave();
    en_note = 8'h00;
    for (int k = 0; k < 40 && m_active; k++) tick();
    oct_up = 1'b1; en_note = 8'h20;
    tick(); tick();
    n_cmp++;
    if ({audio_out, note_active} !== 2'b11) begin
      n_bad++; $display("FAIL oct_start: got %b, want 11", {audio_out, note_active});
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if (audio_out !== (k < 5)) begin
        n_bad++; $display("FAIL oct_half k=%0d: a=%b, want %0d", k, audio_out, (k < 5));
      end
    end
    tick(); tick();
    oct_up = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_cmp++;
      if (audio_out !== m_level || note_active !== m_active ||
          (m_active && note_idx !== m_note[2:0])) begin
        n_bad++;
        $display("FAIL oct_run cyc %0d: got a=%b act=%b, want a=%b act=%b",
                 k, audio_out, note_active, m_level, m_active);
      end
    end
  endtask
`endif

  task automatic test_random();
    int cyc = 0;
    while (cyc < 3000) begin
      int kind = $urandom_range(0, 3);
      int hold = $urandom_range(1, 40);
      if (kind == 0)      en_note = 8'h00;
      else if (kind == 1) en_note = 8'(1 << $urandom_range(0, 7));
      else                en_note = 8'($urandom_range(0, 255));
`ifdef TONE_OCTAVE_SHIFT_EN
      oct_up = 1'($urandom_range(0, 1));
`endif
      rst_n = ($urandom_range(0, 49) != 0);
      for (int k = 0; k < hold; k++) begin
        tick();
        if (k == 0) rst_n = 1'b1;
        cyc++;
        n_cmp++;
        if (audio_out !== m_level || note_active !== m_active ||
            (m_active && note_idx !== m_note[2:0])) begin
          n_bad++;
          $display("FAIL rand cyc %0d: got a=%b act=%b idx=%0d, want a=%b act=%b idx=%0d",
                   cyc, audio_out, note_active, note_idx, m_level, m_active, m_note);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en_note = 8'h00; oct_up = 1'b0;
    test_reset();
    test_note_a();
    test_note_change();
    test_multi_hot();
    test_release();
    test_reset_mid();
`ifdef TONE_OCTAVE_SHIFT_EN
    test_octave();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
